// File: rtl/clk_mgr_ctrl_if.sv
// Control/status bundle between the MMCM supervisor and its surroundings.
//   locked_i     : MMCM locked flag (asynchronous to the supervisor clock)
//   restart_i    : single-cycle request to rerun the full sequence
//   mmcm_rst_o   : MMCM reset, active high
//   rsto         : downstream system reset, active high
//   ready_o      : sequence complete, system running
//   fail_o       : retries exhausted
//   lock_lost_o  : one-cycle pulse when lock drops while running
//   retry_cnt_o  : retries consumed in the current sequence
//   state_o      : FSM state (0 reset, 1 wait-lock, 2 stable, 3 run, 4 fail)
// The slave modport is the supervisor side; master is the driving side.
interface clk_mgr_ctrl_if #(
  parameter int unsigned RTY_W = 3
);
  logic             locked_i;
  logic             restart_i;
  logic             mmcm_rst_o;
  logic             rsto;
  logic             ready_o;
  logic             fail_o;
  logic             lock_lost_o;
  logic [RTY_W-1:0] retry_cnt_o;
  logic [2:0]       state_o;

  modport slave (
    input  locked_i,
    input  restart_i,
    output mmcm_rst_o,
    output rsto,
    output ready_o,
    output fail_o,
    output lock_lost_o,
    output retry_cnt_o,
    output state_o
  );

  modport master (
    output locked_i,
    output restart_i,
    input  mmcm_rst_o,
    input  rsto,
    input  ready_o,
    input  fail_o,
    input  lock_lost_o,
    input  retry_cnt_o,
    input  state_o
  );
endinterface

// File: rtl/clk_mgr_ctrl.sv
// MMCM supervisor/sequencer. Pulses the MMCM reset, waits for a synchronised
// lock, requires the lock to stay up for STABLE_CYC cycles and only then
// releases the downstream reset. Lock timeouts retry up to MAX_RETRY times
// before parking in FAIL. Clocked from the free-running board clock so it
// keeps running while the MMCM is unlocked.
// Ports:
//   clki : free-running input clock
//   rsti : asynchronous active-low reset
//   bus  : control/status bundle (see clk_mgr_ctrl_if)
module clk_mgr_ctrl #(
  parameter int unsigned RST_CYC    = 16,
  parameter int unsigned LOCK_TO    = 65536,
  parameter int unsigned STABLE_CYC = 1024,
  parameter int unsigned MAX_RETRY  = 7,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned RTY_W      = 3
) (
  input  logic                 clki,
  input  logic                 rsti,
  clk_mgr_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TO - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYC - 1);
  localparam logic [RTY_W-1:0] RetryMax   = RTY_W'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             lock_lost_q, lock_lost_d;
  logic             locked_meta_q, locked_s_q;

  // Two-flop synchroniser; the FSM only ever looks at locked_s_q.
  always_ff @(posedge clki or negedge rsti) begin
    if (!rsti) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= bus.locked_i;
      locked_s_q    <= locked_meta_q;
    end
  end

  always_ff @(posedge clki or negedge rsti) begin
    if (!rsti) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    if (bus.restart_i) begin
      // Restart overrides timeout and lock-loss handling in the same cycle.
      state_d = StReset;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StReset: begin
          if (cnt_q == RstLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (locked_s_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == LockLast) begin
            cnt_d = '0;
            if (retry_q == RetryMax) begin
              state_d = StFail;
            end else begin
              state_d = StReset;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStable: begin
          // A drop here is a glitch: keep the retry budget, restart the timeout.
          if (!locked_s_q) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (!locked_s_q) begin
            state_d     = StReset;
            cnt_d       = '0;
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StReset;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Moore decode from registered state.
  assign bus.mmcm_rst_o  = (state_q == StReset) || (state_q == StFail);
  assign bus.rsto        = (state_q != StRun);
  assign bus.ready_o     = (state_q == StRun);
  assign bus.fail_o      = (state_q == StFail);
  assign bus.lock_lost_o = lock_lost_q;
  assign bus.retry_cnt_o = retry_q;
  assign bus.state_o     = state_q;

endmodule
